// File: rtl/sbus_pkg.sv
// Shared definitions for the SB_SPI bus arbiter: register map, FSM encoding
// and the order in which the SPI hard block is configured after reset.
package sbus_pkg;

  localparam logic [7:0] SPICR0  = 8'h08;
  localparam logic [7:0] SPICR1  = 8'h09;
  localparam logic [7:0] SPICR2  = 8'h0A;
  localparam logic [7:0] SPIBR   = 8'h0B;
  localparam logic [7:0] SPISR   = 8'h0C;
  localparam logic [7:0] SPITXDR = 8'h0D;
  localparam logic [7:0] SPIRXDR = 8'h0E;
  localparam logic [7:0] SPICSR  = 8'h0F;

  localparam logic [2:0] INIT_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUS  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Register address for each step of the configuration sequence
  function automatic logic [7:0] init_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    init_addr = SPICR0;
      3'd1:    init_addr = SPICR1;
      3'd2:    init_addr = SPICR2;
      3'd3:    init_addr = SPIBR;
      default: init_addr = SPICSR;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant, registered
// priority pointer that moves past the winner when the grant is taken.
module rr_arbiter3 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  input  logic       i_update,
  output logic [2:0] o_grant
);

  logic [1:0] ptr;
  logic [1:0] gidx;
  logic [2:0] k;
  logic       found;

  // Scan requesters starting at the pointer, first hit wins
  always_comb begin
    o_grant = '0;
    gidx    = ptr;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < 3; i++) begin
      k = {1'b0, ptr} + 3'(i);
      if (k > 3'd2) k = k - 3'd3;
      if (!found && i_req[k[1:0]]) begin
        o_grant[k[1:0]] = 1'b1;
        gidx            = k[1:0];
        found           = 1'b1;
      end
    end
  end

  // Priority moves to the requester after the one just granted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= 2'd0;
    end else if (i_update && found) begin
      ptr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    end
  end

endmodule

// File: rtl/sbus_arbiter.sv
// SB_SPI system-bus arbiter: configures the SPI block after reset, then
// shares the bus among three requesters with round-robin priority, a
// one-cycle gap between transactions and a timeout on missing acks.
module sbus_arbiter
  import sbus_pkg::*;
#(
  parameter logic [7:0] CR0_VAL = 8'h00,
  parameter logic [7:0] CR1_VAL = 8'h80,
  parameter logic [7:0] CR2_VAL = 8'h01,
  parameter logic [7:0] BR_VAL  = 8'h00,
  parameter logic [7:0] CSR_VAL = 8'h00,
  parameter int         TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_req_rw,
  input  logic [23:0] i_req_addr,
  input  logic [23:0] i_req_wdata,
  output logic [2:0]  o_req_ack,
  output logic [2:0]  o_req_err,
  output logic [7:0]  o_rdata,
  output logic        o_init_done,
  output logic        o_sb_stb,
  output logic        o_sb_rw,
  output logic [7:0]  o_sb_addr,
  output logic [7:0]  o_sb_wdata,
  input  logic [7:0]  i_sb_rdata,
  input  logic        i_sb_ack
);

  // Last strobe cycle the counter allows before the transfer is abandoned
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] owner, owner_nxt;
  logic       stb_nxt, rw_nxt, done_nxt, rr_update;
  logic [7:0] addr_nxt, wdata_nxt, rdata_nxt;
  logic [2:0] ack_nxt, err_nxt, grant;
  logic       sel_rw;
  logic [7:0] sel_addr, sel_wdata;

  function automatic logic [7:0] init_data(input logic [2:0] i);
    case (i)
      3'd0:    init_data = CR0_VAL;
      3'd1:    init_data = CR1_VAL;
      3'd2:    init_data = CR2_VAL;
      3'd3:    init_data = BR_VAL;
      default: init_data = CSR_VAL;
    endcase
  endfunction

  rr_arbiter3 u_rr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_update (rr_update),
    .o_grant  (grant)
  );

  // Pick the winning requester's transaction fields
  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      if (grant[k]) begin
        sel_rw    = i_req_rw[k];
        sel_addr  = i_req_addr[8*k +: 8];
        sel_wdata = i_req_wdata[8*k +: 8];
      end
    end
  end

  // Next-state and next-output decode; ack/err/rdata are single-cycle pulses
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    stb_nxt   = o_sb_stb;
    rw_nxt    = o_sb_rw;
    addr_nxt  = o_sb_addr;
    wdata_nxt = o_sb_wdata;
    done_nxt  = o_init_done;
    ack_nxt   = '0;
    err_nxt   = '0;
    rdata_nxt = '0;
    rr_update = 1'b0;
    case (state)
      ST_INIT: begin
        if (!o_sb_stb) begin
          stb_nxt   = 1'b1;
          rw_nxt    = 1'b1;
          addr_nxt  = init_addr(idx);
          wdata_nxt = init_data(idx);
          cnt_nxt   = '0;
        end else if (i_sb_ack) begin
          stb_nxt   = 1'b0;
          state_nxt = ST_GAP;
          if (idx == INIT_LAST) done_nxt = 1'b1;
          else                  idx_nxt  = idx + 3'd1;
        end else if (cnt == TO_LAST) begin
          // Retry the same register after the gap, silently
          stb_nxt   = 1'b0;
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_IDLE: begin
        if (|i_req) begin
          rr_update = 1'b1;
          owner_nxt = grant;
          stb_nxt   = 1'b1;
          rw_nxt    = sel_rw;
          addr_nxt  = sel_addr;
          wdata_nxt = sel_wdata;
          cnt_nxt   = '0;
          state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (i_sb_ack) begin
          stb_nxt   = 1'b0;
          ack_nxt   = owner;
          rdata_nxt = o_sb_rw ? 8'h00 : i_sb_rdata;
          state_nxt = ST_GAP;
        end else if (cnt == TO_LAST) begin
          stb_nxt   = 1'b0;
          ack_nxt   = owner;
          err_nxt   = owner;
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = o_init_done ? ST_IDLE : ST_INIT;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_INIT;
      idx         <= '0;
      cnt         <= '0;
      owner       <= '0;
      o_sb_stb    <= 1'b0;
      o_sb_rw     <= 1'b0;
      o_sb_addr   <= '0;
      o_sb_wdata  <= '0;
      o_req_ack   <= '0;
      o_req_err   <= '0;
      o_rdata     <= '0;
      o_init_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      owner       <= owner_nxt;
      o_sb_stb    <= stb_nxt;
      o_sb_rw     <= rw_nxt;
      o_sb_addr   <= addr_nxt;
      o_sb_wdata  <= wdata_nxt;
      o_req_ack   <= ack_nxt;
      o_req_err   <= err_nxt;
      o_rdata     <= rdata_nxt;
      o_init_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sbus_arbiter.sv
// Directed bench for sbus_arbiter with a simple SB_SPI slave model.
module tb_sbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  req_rw = '0;
  logic [23:0] req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic [2:0]  req_ack, req_err;
  logic [7:0]  rdata;
  logic        init_done;
  logic        sb_stb, sb_rw;
  logic [7:0]  sb_addr, sb_wdata;
  logic [7:0]  sb_rdata = 8'hAA;
  logic        model_ack = 1'b0;
  logic        spur_ack = 1'b0;
  logic        sb_ack;

  assign sb_ack = model_ack | spur_ack;

  sbus_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_req_rw    (req_rw),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_ack   (req_ack),
    .o_req_err   (req_err),
    .o_rdata     (rdata),
    .o_init_done (init_done),
    .o_sb_stb    (sb_stb),
    .o_sb_rw     (sb_rw),
    .o_sb_addr   (sb_addr),
    .o_sb_wdata  (sb_wdata),
    .i_sb_rdata  (sb_rdata),
    .i_sb_ack    (sb_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave model state and logs
  logic       model_en = 1'b1;
  int         lat = 1;
  logic [7:0] rd_val = 8'h00;
  int         wcnt = 0;
  int         stb_cycles = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_d[$];
  logic       sb_w[$];

  // Requester-side log
  logic [2:0] ack_vec[$];
  logic [2:0] ack_err[$];
  logic [7:0] ack_rd[$];
  logic [2:0] prev_ack = '0;
  int         multi = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Slave: acks after lat extra strobe cycles, read data only valid with ack
  always @(negedge clk) begin
    if (sb_stb) stb_cycles++;
    if (sb_stb && model_en) begin
      if (wcnt == lat) begin
        model_ack = 1'b1;
        sb_rdata  = rd_val;
        sb_a.push_back(sb_addr);
        sb_d.push_back(sb_wdata);
        sb_w.push_back(sb_rw);
        wcnt = 0;
      end else begin
        model_ack = 1'b0;
        sb_rdata  = 8'hAA;
        wcnt++;
      end
    end else begin
      model_ack = 1'b0;
      sb_rdata  = 8'hAA;
      wcnt      = 0;
    end
  end

  // Requester-side monitor
  always @(negedge clk) begin
    if (req_ack != '0) begin
      ack_vec.push_back(req_ack);
      ack_err.push_back(req_err);
      ack_rd.push_back(rdata);
      if (prev_ack != '0) multi++;
    end
    prev_ack = req_ack;
  end

  task automatic clear_logs();
    sb_a.delete(); sb_d.delete(); sb_w.delete();
    ack_vec.delete(); ack_err.delete(); ack_rd.delete();
    multi = 0;
  endtask

  task automatic wait_acks(input int n, input int bound, input string tag);
    int c = 0;
    while (ack_vec.size() < n && c < bound) begin
      @(negedge clk); #1; c++;
    end
    chk(tag, 32'(ack_vec.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int bound, input string tag);
    int c = 0;
    while (!init_done && c < bound) begin
      @(negedge clk); #1; c++;
    end
    chk(tag, 32'(init_done), 32'd1);
  endtask

  logic [7:0] exp_a[5] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0F};
  logic [7:0] exp_d[5] = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h00};
  logic [2:0] rr_vec[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [7:0] rr_a[4]   = '{8'h20, 8'h21, 8'h22, 8'h20};
  logic [7:0] rr_d[4]   = '{8'hA0, 8'hA1, 8'hA2, 8'hA0};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stb", 32'(sb_stb), 0);
    chk("rst_rw", 32'(sb_rw), 0);
    chk("rst_addr", 32'(sb_addr), 0);
    chk("rst_wdata", 32'(sb_wdata), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_done", 32'(init_done), 0);

    // Init sequence with a 1-cycle-latency slave
    @(negedge clk); rst_n = 1'b1;
    wait_done(200, "init_done");
    chk("init_count", 32'(sb_a.size()), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("init_addr%0d", i), 32'(sb_a[i]), 32'(exp_a[i]));
      chk($sformatf("init_data%0d", i), 32'(sb_d[i]), 32'(exp_d[i]));
      chk($sformatf("init_rw%0d", i), 32'(sb_w[i]), 1);
    end
    chk("init_no_req_ack", 32'(ack_vec.size()), 0);

    // Stray acks while idle must be ignored
    clear_logs();
    @(negedge clk); spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("spur_no_ack", 32'(ack_vec.size()), 0);
    chk("spur_no_stb", 32'(sb_stb), 0);

    // Three simultaneous, continuous writers
    clear_logs();
    req_rw    = 3'b111;
    req_addr  = {8'h22, 8'h21, 8'h20};
    req_wdata = {8'hA2, 8'hA1, 8'hA0};
    req       = 3'b111;
    wait_acks(4, 100, "rr_wait");
    req = '0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(ack_vec[i]), 32'(rr_vec[i]));
      chk($sformatf("rr_err%0d", i), 32'(ack_err[i]), 0);
      chk($sformatf("rr_rdata%0d", i), 32'(ack_rd[i]), 0);
      chk($sformatf("rr_addr%0d", i), 32'(sb_a[i]), 32'(rr_a[i]));
      chk($sformatf("rr_wdata%0d", i), 32'(sb_d[i]), 32'(rr_d[i]));
    end
    chk("rr_single_pulse", 32'(multi), 0);

    // Requester 1 read with 3-cycle slave latency
    repeat (3) @(negedge clk);
    clear_logs();
    lat = 3; rd_val = 8'h18;
    req_rw = 3'b000; req_addr = {8'h00, 8'h0C, 8'h00};
    req = 3'b010;
    wait_acks(1, 60, "rd_wait");
    req = '0;
    chk("rd_ack", 32'(ack_vec[0]), 3'b010);
    chk("rd_data", 32'(ack_rd[0]), 8'h18);
    chk("rd_err", 32'(ack_err[0]), 0);
    chk("rd_addr", 32'(sb_a[0]), 8'h0C);
    chk("rd_rw", 32'(sb_w[0]), 0);

    // Silent slave: abort after TIMEOUT strobe cycles
    repeat (3) @(negedge clk);
    clear_logs();
    model_en = 1'b0; stb_cycles = 0;
    req_rw = 3'b100; req_addr = {8'h44, 8'h00, 8'h00};
    req = 3'b100;
    wait_acks(1, 80, "to_wait");
    req = '0;
    chk("to_stb_cycles", 32'(stb_cycles), 16);
    chk("to_ack", 32'(ack_vec[0]), 3'b100);
    chk("to_err", 32'(ack_err[0]), 3'b100);
    chk("to_rdata", 32'(ack_rd[0]), 0);

    // Ack on the final allowed strobe cycle beats the timeout
    repeat (3) @(negedge clk);
    clear_logs();
    model_en = 1'b1; lat = 15; rd_val = 8'h5C; stb_cycles = 0;
    req_rw = 3'b000; req_addr = {8'h00, 8'h00, 8'h33};
    req = 3'b001;
    wait_acks(1, 80, "edge_wait");
    req = '0;
    chk("edge_stb_cycles", 32'(stb_cycles), 16);
    chk("edge_ack", 32'(ack_vec[0]), 3'b001);
    chk("edge_err", 32'(ack_err[0]), 0);
    chk("edge_rdata", 32'(ack_rd[0]), 8'h5C);

    // Reset in the middle of a strobe
    repeat (3) @(negedge clk);
    clear_logs();
    model_en = 1'b0;
    req_rw = 3'b001; req = 3'b001;
    begin
      int c = 0;
      while (!sb_stb && c < 20) begin @(negedge clk); c++; end
      chk("mid_stb_seen", 32'(sb_stb), 1);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_stb_drop", 32'(sb_stb), 0);
    chk("mid_done_clr", 32'(init_done), 0);
    chk("mid_no_ack", 32'(req_ack), 0);
    req = '0;
    @(negedge clk);
    lat = 1; model_en = 1'b1; rd_val = 8'h00;
    clear_logs();
    @(negedge clk); rst_n = 1'b1;
    wait_done(200, "reinit_done");
    chk("reinit_count", 32'(sb_a.size()), 5);
    chk("reinit_first", 32'(sb_a[0]), 8'h08);
    chk("reinit_last", 32'(sb_a[4]), 8'h0F);
    chk("reinit_no_ack", 32'(ack_vec.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sbus_arbiter.md
SBUS_ARBITER -- requirements
Module: sbus_arbiter

Interface
REQ-001 Parameters SHALL be: CR0_VAL 8'h00 (SPICR0 init value); CR1_VAL 8'h80 (SPICR1, SPI enable); CR2_VAL 8'h01 (SPICR2, LSB first); BR_VAL 8'h00 (SPIBR); CSR_VAL 8'h00 (SPICSR); TIMEOUT 16 (cycles without ack before abort, range 2..255).
REQ-002 i_clk  in  1  single system clock; one clock; all logic on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_req  in  3  per-requester transaction request, bit k = requester k.
REQ-005 i_req_rw  in  3  per-requester direction, 1 = write, 0 = read.
REQ-006 i_req_addr  in  24  per-requester 8-bit SB address, requester k in bits [8k+7:8k].
REQ-007 i_req_wdata  in  24  per-requester 8-bit write data, same packing.
REQ-008 o_req_ack  out  3  one-cycle completion pulse to the granted requester.
REQ-009 o_req_err  out  3  asserted together with o_req_ack when the transaction timed out.
REQ-010 o_rdata  out  8  read data, valid only in the o_req_ack cycle.
REQ-011 o_init_done  out  1  high once the five-register init sequence has completed.
REQ-012 o_sb_stb, o_sb_rw  out  1 each  SB_SPI SBSTBI / SBRWI.
REQ-013 o_sb_addr, o_sb_wdata  out  8 each  SB_SPI SBADRI / SBDATI.
REQ-014 i_sb_rdata  in  8  SB_SPI SBDATO; i_sb_ack  in  1  SB_SPI SBACKO.

Function
REQ-015 States SHALL be INIT, IDLE, BUS, GAP.
REQ-016 INIT: write CR0, CR1, CR2, BR, CSR in that order (addresses 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0F) with the parameter values; no requester is granted; o_req_ack stays 0.
REQ-017 During INIT, each register is written with the same strobe/ack rules as BUS; after the CSR ack, o_init_done rises the next cycle and the state goes to GAP.
REQ-018 IDLE: when any i_req bit is high, grant one requester round-robin, latch its rw/addr/wdata, assert o_sb_stb the next cycle, and go to BUS.
REQ-019 Round-robin: priority starts at the requester after the last granted one; after reset, requester 0 has priority.
REQ-020 BUS: o_sb_stb and the latched fields SHALL stay constant until i_sb_ack=1 is sampled.
REQ-021 On ack: deassert o_sb_stb in the next cycle; in that same cycle pulse o_req_ack[grant]; o_rdata = i_sb_rdata as captured at the ack (reads only, 8'h00 for writes); then go to GAP.
REQ-022 GAP: exactly one cycle with o_sb_stb=0, then IDLE.
REQ-023 Back-to-back requests SHALL therefore complete no faster than one transaction per 4 cycles with a 1-cycle ack.
REQ-024 A timeout counter SHALL reset on each new strobe and increment each BUS cycle without ack.
REQ-025 When the counter reaches TIMEOUT: deassert o_sb_stb, pulse o_req_ack and o_req_err for the grant, set o_rdata=0, go to GAP.
REQ-026 A timeout in INIT SHALL retry the same register after GAP; o_req_err is not driven in INIT.
REQ-027 If i_sb_ack and the timeout coincide, ack wins and no error is reported.
REQ-028 If the granted requester drops i_req mid-transaction, the transaction still completes and the ack pulse is issued.
REQ-029 Requesters SHALL hold i_req and their fields until their ack; the ungranted requesters wait.
REQ-030 i_sb_ack outside BUS/INIT strobe cycles SHALL be ignored.

Reset
REQ-031 On i_rst_n=0, immediately: o_sb_stb=0, o_sb_rw=0, o_sb_addr=0, o_sb_wdata=0, o_req_ack=0, o_req_err=0, o_rdata=0, o_init_done=0, state=INIT at index 0, round-robin pointer=requester 0, timeout counter=0.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no ack, and the full init sequence SHALL rerun after release.

Structure
REQ-033 Package sbus_pkg SHALL hold the SB_SPI register address constants (SPICR0..SPISR) and the state encoding.
REQ-034 A sub-module rr_arbiter3 SHALL provide the registered round-robin pointer and the one-hot grant from a 3-bit request vector.

Verification
REQ-035 Reset release with an SB model acking after 1 cycle -> five writes to 08/09/0A/0B/0F with data 00/80/01/00/00, then o_init_done=1.
REQ-036 Requesters 0, 1 and 2 request simultaneously and continuously -> grant order 0,1,2,0; each ack pulses exactly one cycle.
REQ-037 Requester 1 reads addr 8'h0C while the model returns 8'h18 with ack after 3 cycles -> o_rdata=8'h18 in the o_req_ack[1] cycle, o_req_err=0.
REQ-038 Model never acks and TIMEOUT=16 -> strobe held 16 cycles, then o_req_ack and o_req_err pulse for the grant, o_rdata=0.
REQ-039 i_rst_n pulsed low while BUS is strobing -> o_sb_stb drops immediately, no ack, and init restarts at CR0.
